ddr_read_arbiter: RTL and testbench

- Parametrised N-channel successor to the fixed 3-way DDR read mux.
- Replaces the external `switch` select with an internal request queue and round-robin arbiter, per-channel burst tracking and completion pulses.
- Sits between the layer loaders (bias/weights/data/extra) and the single DDR read interface: one outstanding descriptor per channel, one DDR burst in flight at a time.

---
 rtl/ddr_read_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_ddr_read_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_read_arbiter.sv
// Purpose: arbitrate N loader channels onto one DDR read face with a round-robin
//          pick, per-channel descriptor slots, burst beat tracking and done pulses.
// Latency: conf -> pending +1 cycle -> ddr_conf +2 cycles; pops pass through combinationally.
// Backpressure: the granted channel's pop is forwarded to DDR only while streaming; others see empty.
module ddr_read_arbiter #(
    parameter int NUM_CH       = 4,
    parameter int CH_BITS      = 2,
    parameter int SINGLE_LEN   = 20,
    parameter int DDR_DATA_LEN = 512,
    parameter int DDR_ADDR_LEN = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic [DDR_ADDR_LEN-1:0]        ddr_st_addr_out,
    output logic [SINGLE_LEN-1:0]          ddr_len,
    output logic                           ddr_conf,
    input  logic                           ddr_fifo_empty,
    output logic                           ddr_fifo_req,
    input  logic [DDR_DATA_LEN-1:0]        ddr_fifo_data,
    input  logic [NUM_CH*DDR_ADDR_LEN-1:0] ch_st_addr,
    input  logic [NUM_CH*SINGLE_LEN-1:0]   ch_len,
    input  logic [NUM_CH-1:0]              ch_conf,
    output logic [NUM_CH-1:0]              ch_fifo_empty,
    input  logic [NUM_CH-1:0]              ch_fifo_req,
    output logic [DDR_DATA_LEN-1:0]        ch_fifo_data,
    output logic [NUM_CH-1:0]              ch_busy,
    output logic [NUM_CH-1:0]              ch_done,
    output logic [NUM_CH-1:0]              ch_drop
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    localparam logic [SINGLE_LEN-1:0] LEN_ONE  = SINGLE_LEN'(1);
    localparam logic [SINGLE_LEN-1:0] LEN_ZERO = '0;

    state_t                    r_state;
    logic [CH_BITS-1:0]        r_grant;
    logic [CH_BITS-1:0]        r_last_grant;
    logic [NUM_CH-1:0]         r_pending;
    logic [NUM_CH-1:0]         r_drop;
    logic [SINGLE_LEN-1:0]     r_beat_cnt;
    logic [SINGLE_LEN-1:0]     r_ddr_len;
    logic [DDR_ADDR_LEN-1:0]   r_ddr_addr;
    logic                      r_ddr_conf;

    // One descriptor slot per channel; only written when the descriptor is accepted.
    logic [DDR_ADDR_LEN-1:0]   r_slot_addr [NUM_CH];
    logic [SINGLE_LEN-1:0]     r_slot_len  [NUM_CH];

    logic [NUM_CH-1:0]         w_grant_oh;
    logic [NUM_CH-1:0]         w_active;
    logic [NUM_CH-1:0]         w_done;
    logic [NUM_CH-1:0]         w_accept;
    logic [NUM_CH-1:0]         w_clear;
    logic [NUM_CH-1:0]         w_empty_view;
    logic                      w_pick_vld;
    logic [CH_BITS-1:0]        w_pick_idx;
    logic                      w_streaming;
    logic                      w_fifo_req;
    logic                      w_pop;
    logic                      w_last_beat;

    assign w_streaming = (r_state == S_STREAM);
    assign w_fifo_req  = w_streaming & ch_fifo_req[r_grant];
    assign w_pop       = w_fifo_req & ~ddr_fifo_empty;
    assign w_last_beat = w_pop & (r_beat_cnt == (r_ddr_len - LEN_ONE));

    // One-hot view of the current grant, qualified by a burst actually being in progress.
    always_comb begin
        w_grant_oh          = '0;
        w_grant_oh[r_grant] = 1'b1;
        w_active            = (r_state != S_IDLE) ? w_grant_oh : '0;
    end

    // Completion pulse: zero-length bursts finish in ISSUE, others on their final pop.
    always_comb begin
        w_done = '0;
        if ((r_state == S_ISSUE) && (r_ddr_len == LEN_ZERO)) begin
            w_done[r_grant] = 1'b1;
        end
        if (w_last_beat) begin
            w_done[r_grant] = 1'b1;
        end
    end

    // A descriptor is taken when its channel is free, or is finishing in this very cycle.
    always_comb begin
        w_accept = ch_conf & ((~r_pending & ~w_active) | w_done);
    end

    // Round-robin search starting one past the last grant, wrapping around.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!w_pick_vld &&
                r_pending[CH_BITS'((int'(r_last_grant) + k) % NUM_CH)]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = CH_BITS'((int'(r_last_grant) + k) % NUM_CH);
            end
        end
    end

    // Pending bit of the channel being granted is released as the FSM leaves IDLE.
    always_comb begin
        w_clear = '0;
        if ((r_state == S_IDLE) && w_pick_vld) begin
            w_clear[w_pick_idx] = 1'b1;
        end
    end

    // Only the granted channel sees the real FIFO state, and only during the data phase.
    always_comb begin
        w_empty_view = '1;
        if (w_streaming) begin
            w_empty_view[r_grant] = ddr_fifo_empty;
        end
    end

    // Descriptor slots and the sticky drop flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_slot_addr[i] <= '0;
                r_slot_len[i]  <= '0;
            end
        end else begin
            r_drop <= r_drop | (ch_conf & ~w_accept);
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_accept[i]) begin
                    r_slot_addr[i] <= ch_st_addr[i*DDR_ADDR_LEN +: DDR_ADDR_LEN];
                    r_slot_len[i]  <= ch_len[i*SINGLE_LEN +: SINGLE_LEN];
                end
            end
        end
    end

    // Burst sequencer: pick a pending channel, issue its burst, count beats to completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= CH_BITS'(NUM_CH - 1);
            r_pending    <= '0;
            r_beat_cnt   <= '0;
            r_ddr_len    <= '0;
            r_ddr_addr   <= '0;
            r_ddr_conf   <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | w_accept;
            case (r_state)
                S_IDLE: begin
                    r_ddr_conf <= 1'b0;
                    if (w_pick_vld) begin
                        r_grant      <= w_pick_idx;
                        r_last_grant <= w_pick_idx;
                        r_ddr_addr   <= r_slot_addr[w_pick_idx];
                        r_ddr_len    <= r_slot_len[w_pick_idx];
                        // Zero-length bursts never strobe the DDR face.
                        r_ddr_conf   <= (r_slot_len[w_pick_idx] != LEN_ZERO);
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_ddr_conf <= 1'b0;
                    r_beat_cnt <= '0;
                    r_state    <= (r_ddr_len == LEN_ZERO) ? S_IDLE : S_STREAM;
                end
                S_STREAM: begin
                    r_ddr_conf <= 1'b0;
                    if (w_pop) begin
                        r_beat_cnt <= r_beat_cnt + LEN_ONE;
                    end
                    if (w_last_beat) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_ddr_conf <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign ddr_st_addr_out = r_ddr_addr;
    assign ddr_len         = r_ddr_len;
    assign ddr_conf        = r_ddr_conf;
    assign ddr_fifo_req    = w_fifo_req;
    assign ch_fifo_empty   = w_empty_view;
    assign ch_fifo_data    = ddr_fifo_data;
    assign ch_busy         = r_pending | w_active;
    assign ch_done         = w_done;
    assign ch_drop         = r_drop;

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Directed bench for ddr_read_arbiter: reset, single burst, round robin,
// zero length / empty stalls, drop and isolation, reset mid-burst.
module tb_ddr_read_arbiter;

    localparam int NUM_CH = 4;
    localparam int CH_BITS = 2;
    localparam int SL = 20;
    localparam int DL = 512;
    localparam int AL = 32;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [AL-1:0]         ddr_st_addr_out;
    logic [SL-1:0]         ddr_len;
    logic                  ddr_conf;
    logic                  ddr_fifo_empty = 1'b1;
    logic                  ddr_fifo_req;
    logic [DL-1:0]         ddr_fifo_data = '0;
    logic [NUM_CH*AL-1:0]  ch_st_addr = '0;
    logic [NUM_CH*SL-1:0]  ch_len = '0;
    logic [NUM_CH-1:0]     ch_conf = '0;
    logic [NUM_CH-1:0]     ch_fifo_empty;
    logic [NUM_CH-1:0]     ch_fifo_req = '0;
    logic [DL-1:0]         ch_fifo_data;
    logic [NUM_CH-1:0]     ch_busy;
    logic [NUM_CH-1:0]     ch_done;
    logic [NUM_CH-1:0]     ch_drop;

    int tests = 0;
    int fails = 0;

    ddr_read_arbiter #(
        .NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .SINGLE_LEN(SL),
        .DDR_DATA_LEN(DL), .DDR_ADDR_LEN(AL)
    ) dut (
        .clk(clk), .rst(rst),
        .ddr_st_addr_out(ddr_st_addr_out), .ddr_len(ddr_len), .ddr_conf(ddr_conf),
        .ddr_fifo_empty(ddr_fifo_empty), .ddr_fifo_req(ddr_fifo_req),
        .ddr_fifo_data(ddr_fifo_data),
        .ch_st_addr(ch_st_addr), .ch_len(ch_len), .ch_conf(ch_conf),
        .ch_fifo_empty(ch_fifo_empty), .ch_fifo_req(ch_fifo_req),
        .ch_fifo_data(ch_fifo_data),
        .ch_busy(ch_busy), .ch_done(ch_done), .ch_drop(ch_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int ch, input logic [AL-1:0] a, input logic [SL-1:0] l);
        ch_st_addr[ch*AL +: AL] = a;
        ch_len[ch*SL +: SL]     = l;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ch_conf = '0; ch_fifo_req = '0; ddr_fifo_empty = 1'b1;
        ddr_fifo_data = '0; ch_st_addr = '0; ch_len = '0;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ch_conf = 4'hF; ch_fifo_req = 4'hF; ddr_fifo_empty = 1'b0;
        repeat (2) cyc();
        tests++; if (ddr_conf !== 1'b0) begin fails++; $display("FAIL rst_conf: got %b want 0", ddr_conf); end
        tests++; if (ddr_st_addr_out !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h want 0", ddr_st_addr_out); end
        tests++; if (ddr_len !== 20'h0) begin fails++; $display("FAIL rst_len: got %h want 0", ddr_len); end
        tests++; if (ddr_fifo_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", ddr_fifo_req); end
        tests++; if (ch_fifo_empty !== 4'hF) begin fails++; $display("FAIL rst_empty: got %b want 1111", ch_fifo_empty); end
        tests++; if ({ch_busy, ch_done, ch_drop} !== 12'h0) begin fails++; $display("FAIL rst_flags: got %h want 000", {ch_busy, ch_done, ch_drop}); end
        rst = 1'b0;
        ch_conf = '0; ch_fifo_req = '0; ddr_fifo_empty = 1'b1;
        cyc();
    endtask

    task automatic test_single_burst();
        do_reset();
        set_slot(1, 32'h1000, 20'd4);
        ch_conf = 4'b0010; ch_fifo_req = 4'b0010; ddr_fifo_empty = 1'b0;
        ddr_fifo_data = {16{32'hA5C3_0F1E}};
        #1;
        tests++; if (ch_busy !== 4'b0000) begin fails++; $display("FAIL sb_busy_c0: got %b want 0000", ch_busy); end
        tests++; if (ch_fifo_data !== {16{32'hA5C3_0F1E}}) begin fails++; $display("FAIL sb_data: got %h want a5c30f1e repeated", ch_fifo_data[31:0]); end
        cyc(); ch_conf = '0; #1;
        tests++; if (ch_busy !== 4'b0010) begin fails++; $display("FAIL sb_busy_c1: got %b want 0010", ch_busy); end
        tests++; if (ddr_conf !== 1'b0) begin fails++; $display("FAIL sb_conf_c1: got %b want 0", ddr_conf); end
        cyc(); #1;
        tests++; if (ddr_conf !== 1'b1) begin fails++; $display("FAIL sb_conf_c2: got %b want 1", ddr_conf); end
        tests++; if (ddr_st_addr_out !== 32'h1000) begin fails++; $display("FAIL sb_addr: got %h want 1000", ddr_st_addr_out); end
        tests++; if (ddr_len !== 20'd4) begin fails++; $display("FAIL sb_len: got %0d want 4", ddr_len); end
        tests++; if (ddr_fifo_req !== 1'b0) begin fails++; $display("FAIL sb_req_issue: got %b want 0", ddr_fifo_req); end
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            tests++; if ({ddr_conf, ddr_fifo_req} !== 2'b01) begin fails++; $display("FAIL sb_pop%0d: conf,req got %b want 01", k, {ddr_conf, ddr_fifo_req}); end
            tests++; if (ch_done !== ((k == 3) ? 4'b0010 : 4'b0000)) begin fails++; $display("FAIL sb_done%0d: got %b want %b", k, ch_done, (k == 3) ? 4'b0010 : 4'b0000); end
        end
        cyc(); #1;
        tests++; if (ch_busy !== 4'b0000) begin fails++; $display("FAIL sb_busy_end: got %b want 0000", ch_busy); end
        tests++; if ({ddr_fifo_req, ch_done} !== 5'b0) begin fails++; $display("FAIL sb_idle_end: req,done got %b want 00000", {ddr_fifo_req, ch_done}); end
    endtask

    task automatic test_round_robin();
        logic [AL-1:0] q_addr[$];
        int            q_cyc[$];
        logic [3:0]    q_done[$];
        do_reset();
        for (int i = 0; i < 4; i++) set_slot(i, 32'h2000 + 32'(i) * 32'h10, 20'd2);
        ch_conf = 4'hF; ch_fifo_req = 4'hF; ddr_fifo_empty = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (c == 1) ch_conf = '0;
            #1;
            if (ddr_conf) begin q_addr.push_back(ddr_st_addr_out); q_cyc.push_back(c); end
            if (ch_done != 4'b0) q_done.push_back(ch_done);
            cyc();
        end
        tests++; if (q_addr.size() != 4 || q_done.size() != 4) begin fails++; $display("FAIL rr_count: bursts %0d dones %0d want 4 4", q_addr.size(), q_done.size()); end
        for (int i = 0; i < 4; i++) begin
            if (q_addr.size() > i) begin
                tests++; if (q_addr[i] !== 32'h2000 + 32'(i) * 32'h10) begin fails++; $display("FAIL rr_order%0d: addr %h want %h", i, q_addr[i], 32'h2000 + 32'(i) * 32'h10); end
                tests++; if (q_cyc[i] != 2 + 4 * i) begin fails++; $display("FAIL rr_cycle%0d: conf at %0d want %0d", i, q_cyc[i], 2 + 4 * i); end
            end
            if (q_done.size() > i) begin
                tests++; if (q_done[i] !== 4'(1 << i)) begin fails++; $display("FAIL rr_done%0d: got %b want %b", i, q_done[i], 4'(1 << i)); end
            end
        end
        // last grant is now 3: channel 0 must win over channel 3
        q_addr.delete(); q_done.delete(); q_cyc.delete();
        set_slot(0, 32'h2100, 20'd2);
        set_slot(3, 32'h2130, 20'd2);
        ch_conf = 4'b1001;
        for (int c = 0; c < 14; c++) begin
            if (c == 1) ch_conf = '0;
            #1;
            if (ddr_conf) q_addr.push_back(ddr_st_addr_out);
            if (ch_done != 4'b0) q_done.push_back(ch_done);
            cyc();
        end
        tests++; if (q_addr.size() != 2 || q_done.size() != 2) begin fails++; $display("FAIL rr2_count: bursts %0d dones %0d want 2 2", q_addr.size(), q_done.size()); end
        else begin
            tests++; if ({q_addr[0], q_addr[1]} !== {32'h2100, 32'h2130}) begin fails++; $display("FAIL rr2_order: got %h %h want 2100 2130", q_addr[0], q_addr[1]); end
            tests++; if ({q_done[0], q_done[1]} !== 8'b0001_1000) begin fails++; $display("FAIL rr2_done: got %b %b want 0001 1000", q_done[0], q_done[1]); end
        end
        ch_fifo_req = '0;
    endtask

    task automatic test_zero_and_stall();
        int pops;
        logic any_conf;
        do_reset();
        set_slot(2, 32'h3000, 20'd0);
        ch_conf = 4'b0100;
        any_conf = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) ch_conf = '0;
            #1;
            if (ddr_conf) any_conf = 1'b1;
            tests++; if (ch_done !== ((c == 2) ? 4'b0100 : 4'b0000)) begin fails++; $display("FAIL zl_done_c%0d: got %b want %b", c, ch_done, (c == 2) ? 4'b0100 : 4'b0000); end
            cyc();
        end
        tests++; if (any_conf !== 1'b0) begin fails++; $display("FAIL zl_conf: ddr_conf seen %b want 0", any_conf); end
        tests++; if (ch_busy !== 4'b0) begin fails++; $display("FAIL zl_busy: got %b want 0000", ch_busy); end
        // len 3 with the DDR FIFO empty on odd cycles: pops land on cycles 4, 6, 8
        set_slot(0, 32'h4000, 20'd3);
        ch_conf = 4'b0001; ch_fifo_req = 4'b0001;
        pops = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 1) ch_conf = '0;
            ddr_fifo_empty = (c % 2 == 1);
            #1;
            if (ddr_fifo_req && !ddr_fifo_empty) pops++;
            tests++; if (ch_fifo_empty !== {3'b111, (c >= 3 && c <= 8) ? ddr_fifo_empty : 1'b1}) begin fails++; $display("FAIL st_empty_c%0d: got %b", c, ch_fifo_empty); end
            tests++; if (ch_done !== ((c == 8) ? 4'b0001 : 4'b0000)) begin fails++; $display("FAIL st_done_c%0d: got %b want %b", c, ch_done, (c == 8) ? 4'b0001 : 4'b0000); end
            cyc();
        end
        tests++; if (pops != 3) begin fails++; $display("FAIL st_pops: got %0d want 3", pops); end
        ch_fifo_req = '0; ddr_fifo_empty = 1'b1;
    endtask

    task automatic test_drop_isolation();
        do_reset();
        set_slot(0, 32'h5000, 20'd4);
        ch_conf = 4'b0001; ch_fifo_req = 4'b0001; ddr_fifo_empty = 1'b0;
        for (int c = 0; c < 12; c++) begin
            case (c)
                1: ch_conf = '0;
                4: begin set_slot(0, 32'h6000, 20'd7); ch_conf = 4'b0001; end
                5: begin ch_conf = '0; ch_fifo_req = 4'b1000; end
                6: ch_fifo_req = 4'b1001;
                7: begin set_slot(0, 32'h7000, 20'd1); ch_conf = 4'b0001; end
                8: ch_conf = '0;
                default: ;
            endcase
            #1;
            case (c)
                2: begin
                    tests++; if ({ddr_conf, ddr_st_addr_out, ddr_len} !== {1'b1, 32'h5000, 20'd4}) begin fails++; $display("FAIL dr_issue: conf %b addr %h len %0d want 1 5000 4", ddr_conf, ddr_st_addr_out, ddr_len); end
                end
                5: begin
                    tests++; if (ch_drop !== 4'b0001) begin fails++; $display("FAIL dr_drop: got %b want 0001", ch_drop); end
                    tests++; if (ddr_fifo_req !== 1'b0) begin fails++; $display("FAIL dr_iso_req: got %b want 0", ddr_fifo_req); end
                    tests++; if (ch_fifo_empty !== 4'b1110) begin fails++; $display("FAIL dr_iso_empty: got %b want 1110", ch_fifo_empty); end
                end
                6: begin
                    tests++; if (ddr_fifo_req !== 1'b1) begin fails++; $display("FAIL dr_track: got %b want 1", ddr_fifo_req); end
                end
                7: begin
                    tests++; if (ch_done !== 4'b0001) begin fails++; $display("FAIL dr_done1: got %b want 0001", ch_done); end
                end
                9: begin
                    tests++; if ({ddr_conf, ddr_st_addr_out, ddr_len} !== {1'b1, 32'h7000, 20'd1}) begin fails++; $display("FAIL dr_reissue: conf %b addr %h len %0d want 1 7000 1", ddr_conf, ddr_st_addr_out, ddr_len); end
                end
                10: begin
                    tests++; if (ch_done !== 4'b0001) begin fails++; $display("FAIL dr_done2: got %b want 0001", ch_done); end
                end
                11: begin
                    tests++; if ({ch_drop, ch_busy} !== 8'b0001_0000) begin fails++; $display("FAIL dr_end: drop,busy got %b want 00010000", {ch_drop, ch_busy}); end
                end
                default: ;
            endcase
            cyc();
        end
        ch_fifo_req = '0;
    endtask

    task automatic test_reset_mid_burst();
        logic activity;
        do_reset();
        set_slot(0, 32'h8000, 20'd8);
        ch_conf = 4'b0001; ch_fifo_req = 4'b0001; ddr_fifo_empty = 1'b0;
        cyc();
        set_slot(1, 32'h9000, 20'd2); ch_conf = 4'b0010;
        cyc();
        ch_conf = '0;
        repeat (3) cyc();            // cycle 5: two pops done (cycles 3, 4)
        rst = 1'b1;
        #1;
        tests++; if ({ddr_conf, ddr_st_addr_out, ddr_len} !== 53'h0) begin fails++; $display("FAIL mr_face: conf %b addr %h len %h want zeros", ddr_conf, ddr_st_addr_out, ddr_len); end
        tests++; if ({ddr_fifo_req, ch_fifo_empty} !== 5'b01111) begin fails++; $display("FAIL mr_fifo: req,empty got %b want 01111", {ddr_fifo_req, ch_fifo_empty}); end
        tests++; if ({ch_busy, ch_done, ch_drop} !== 12'h0) begin fails++; $display("FAIL mr_flags: got %h want 000", {ch_busy, ch_done, ch_drop}); end
        cyc();
        rst = 1'b0;
        activity = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (ddr_conf || ddr_fifo_req || ch_busy != 4'b0) activity = 1'b1;
            cyc();
        end
        tests++; if (activity !== 1'b0) begin fails++; $display("FAIL mr_quiet: activity %b want 0", activity); end
        set_slot(2, 32'hA000, 20'd1); ch_conf = 4'b0100;
        cyc(); ch_conf = '0;
        cyc(); #1;
        tests++; if ({ddr_conf, ddr_st_addr_out, ch_busy} !== {1'b1, 32'hA000, 4'b0100}) begin fails++; $display("FAIL mr_new: conf %b addr %h busy %b want 1 a000 0100", ddr_conf, ddr_st_addr_out, ch_busy); end
        ch_fifo_req = '0;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_zero_and_stall();
        test_drop_isolation();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
